ps2_scan_decoder: RTL and testbench

PS2_SCAN_DECODER -- requirements
Module: ps2_scan_decoder

---
 rtl/ps2_scan_decoder.sv | 166 ++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-code decoder: synchronizes the receive-stage handshake, captures
// bytes, folds E0/F0 prefixes into make/break events and queues them in a
// show-ahead FIFO with a sticky overflow flag.
module ps2_scan_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_ready,
    output logic       read,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    input  logic       ev_pop,
    output logic [4:0] ev_count,
    output logic       overflow,
    input  logic       clr_ovf
);

    localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ev_t;

    // ---------------- handshake / capture ----------------
    logic       sync1_q, rdy_s_q;
    logic       busy_q, read_q, byte_vld_q;
    logic [7:0] byte_q;

    // Two-flop synchronizer for the asynchronous byte-ready level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            rdy_s_q <= 1'b0;
        end else begin
            sync1_q <= scan_ready;
            rdy_s_q <= sync1_q;
        end
    end

    // Capture once per ready level; busy holds off re-capture until ready drops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q     <= 1'b0;
            read_q     <= 1'b0;
            byte_vld_q <= 1'b0;
            byte_q     <= 8'h00;
        end else begin
            read_q     <= 1'b0;
            byte_vld_q <= 1'b0;
            if (!rdy_s_q) begin
                busy_q <= 1'b0;
            end else if (!busy_q) begin
                busy_q     <= 1'b1;
                read_q     <= 1'b1;
                byte_vld_q <= 1'b1;
                byte_q     <= scan_code;
            end
        end
    end

    assign read = read_q;

    // ---------------- prefix decoder ----------------
    state_t state_q, state_d;
    logic   push_q, push_d;
    ev_t    ev_q, ev_d;

    // Decoder state and registered event (one cycle after capture)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            push_q  <= 1'b0;
            ev_q    <= '0;
        end else begin
            state_q <= state_d;
            push_q  <= push_d;
            ev_q    <= ev_d;
        end
    end

    // Next-state and event generation from the captured byte
    always_comb begin
        state_d = state_q;
        push_d  = 1'b0;
        ev_d    = ev_q;
        if (byte_vld_q) begin
            unique case (byte_q)
                8'hE0: begin
                    if (state_q == IDLE) state_d = EXT;
                end
                8'hF0: begin
                    if (state_q == IDLE)     state_d = BRK;
                    else if (state_q == EXT) state_d = EXT_BRK;
                end
                // Keyboard status/response bytes carry no key information
                8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin
                    state_d = IDLE;
                end
                default: begin
                    push_d      = 1'b1;
                    ev_d.ext    = (state_q == EXT) || (state_q == EXT_BRK);
                    ev_d.brk    = (state_q == BRK) || (state_q == EXT_BRK);
                    ev_d.code   = byte_q;
                    state_d     = IDLE;
                end
            endcase
        end
    end

    // ---------------- event FIFO ----------------
    ev_t           mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [4:0]    count_q;
    logic          ovf_q;
    logic          empty, full, pop_ok, push_ok, drop;

    assign empty   = (count_q == 5'd0);
    assign full    = (count_q == DEPTH_C);
    assign pop_ok  = ev_pop && !empty;
    assign push_ok = push_q && (!full || pop_ok);
    assign drop    = push_q && full && !pop_ok;

    // Storage array; contents need no reset since outputs are gated by valid
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= ev_q;
    end

    // Pointers, occupancy and sticky overflow (a drop wins over clear)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= 5'd0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop_ok)  rd_q <= rd_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 5'd1;
                2'b01:   count_q <= count_q - 5'd1;
                default: count_q <= count_q;
            endcase
            if (drop)         ovf_q <= 1'b1;
            else if (clr_ovf) ovf_q <= 1'b0;
        end
    end

    ev_t head;
    assign head     = mem_q[rd_q];
    assign ev_valid = !empty;
    assign ev_code  = ev_valid ? head.code : 8'h00;
    assign ev_ext   = ev_valid && head.ext;
    assign ev_break = ev_valid && head.brk;
    assign ev_count = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: prefix decoding, handshake, FIFO
// full/overflow behaviour and mid-sequence reset.
module tb_ps2_scan_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] scan_code;
    logic       scan_ready;
    logic       read;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       ev_pop;
    logic [4:0] ev_count;
    logic       overflow;
    logic       clr_ovf;

    int checks   = 0;
    int failures = 0;
    int reads    = 0;
    int base;

    ps2_scan_decoder #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_code  (scan_code),
        .scan_ready (scan_ready),
        .read       (read),
        .ev_valid   (ev_valid),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_break   (ev_break),
        .ev_pop     (ev_pop),
        .ev_count   (ev_count),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    // Count acknowledge pulses away from the active edge
    always @(negedge clk) if (read === 1'b1) reads++;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Head as {ext, break, code}
    function automatic logic [31:0] head();
        return {22'd0, ev_ext, ev_break, ev_code};
    endfunction

    // Present a byte, wait (bounded) for read, then drop ready like the receive stage
    task automatic wait_read(input string tag);
        int n = 0;
        while (read !== 1'b1 && n < 20) begin
            cyc(1);
            n++;
        end
        if (read !== 1'b1) begin
            checks++;
            failures++;
            $error("FAIL %s observed=no_read expected=read_pulse", tag);
        end
    endtask

    task automatic send(input logic [7:0] b);
        scan_code  = b;
        scan_ready = 1'b1;
        wait_read("read_timeout");
        scan_ready = 1'b0;
        cyc(6);
    endtask

    task automatic pop();
        ev_pop = 1'b1;
        cyc(1);
        ev_pop = 1'b0;
    endtask

    // Byte whose FIFO write coincides with a pop (write lands two edges after read)
    task automatic send_with_pop(input logic [7:0] b);
        scan_code  = b;
        scan_ready = 1'b1;
        wait_read("read_timeout_sp");
        scan_ready = 1'b0;
        cyc(1);
        ev_pop = 1'b1;
        cyc(1);
        ev_pop = 1'b0;
        cyc(4);
    endtask

    initial begin
        reset = 1'b0; scan_code = 8'h00; scan_ready = 1'b0; ev_pop = 1'b0; clr_ovf = 1'b0;
        cyc(3);
        // {read, ev_valid, ev_count, overflow, ev_code, ev_ext, ev_break}
        chk("reset_outputs", {read, ev_valid, ev_count, overflow, ev_code, ev_ext, ev_break}, 32'h0);
        reset = 1'b1;
        cyc(2);

        // Make then break of 0x1C
        base = reads;
        send(8'h1C);
        chk("make_1c", head(), {22'd0, 2'b00, 8'h1C});
        pop();
        send(8'hF0);
        send(8'h1C);
        chk("break_1c", head(), {22'd0, 2'b01, 8'h1C});
        chk("read_pulses_3", reads - base, 32'd3);
        pop();
        chk("empty_after_pops", {27'd0, ev_count}, 32'd0);

        // Extended make and break
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        chk("ext_count", {27'd0, ev_count}, 32'd2);
        chk("ext_make_75", head(), {22'd0, 2'b10, 8'h75});
        pop();
        chk("ext_break_75", head(), {22'd0, 2'b11, 8'h75});
        pop();

        // Pop while empty is ignored
        pop();
        chk("pop_empty_ignored", {26'd0, ev_valid, ev_count}, 32'd0);

        // Ready held high for 10 cycles: one capture only
        base = reads;
        scan_code = 8'h2A; scan_ready = 1'b1;
        cyc(10);
        scan_ready = 1'b0;
        cyc(6);
        chk("held_ready_reads", reads - base, 32'd1);
        chk("held_ready_count", {27'd0, ev_count}, 32'd1);
        chk("held_ready_code", head(), {22'd0, 2'b00, 8'h2A});
        pop();

        // Push and pop together while empty: push taken, pop ignored
        send_with_pop(8'h2B);
        chk("empty_push_pop_count", {27'd0, ev_count}, 32'd1);
        chk("empty_push_pop_head", head(), {22'd0, 2'b00, 8'h2B});
        pop();

        // Overflow: five makes into depth 4
        send(8'h15); send(8'h16); send(8'h17); send(8'h18); send(8'h19);
        chk("ovf_count", {27'd0, ev_count}, 32'd4);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_head", head(), {22'd0, 2'b00, 8'h15});

        // Pop then clear
        pop();
        chk("ovf_sticky_after_pop", {31'd0, overflow}, 32'd1);
        clr_ovf = 1'b1; cyc(1); clr_ovf = 1'b0;
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Refill to full then push+pop in the same cycle
        send(8'h1A);
        chk("refill_full", {27'd0, ev_count}, 32'd4);
        send_with_pop(8'h1B);
        chk("full_push_pop_count", {27'd0, ev_count}, 32'd4);
        chk("full_push_pop_ovf", {31'd0, overflow}, 32'd0);
        chk("order_0", head(), {22'd0, 2'b00, 8'h17}); pop();
        chk("order_1", head(), {22'd0, 2'b00, 8'h18}); pop();
        chk("order_2", head(), {22'd0, 2'b00, 8'h1A}); pop();
        chk("order_3", head(), {22'd0, 2'b00, 8'h1B}); pop();
        chk("drained", {27'd0, ev_count}, 32'd0);

        // Discarded byte, then prefix lost to reset
        send(8'hAA);
        chk("aa_discarded", {26'd0, ev_valid, ev_count}, 32'd0);
        send(8'hE0);
        reset = 1'b0;
        cyc(2);
        chk("midreset_outputs", {read, ev_valid, ev_count, overflow, ev_code, ev_ext, ev_break}, 32'h0);
        reset = 1'b1;
        cyc(2);
        send(8'h1C);
        chk("post_reset_idle_decode", head(), {22'd0, 2'b00, 8'h1C});
        chk("post_reset_count", {27'd0, ev_count}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
